// File: rtl/bcd_updown_cnt_n.sv
// bcd_updown_cnt_n: parametrised N-digit BCD up/down counter.
//
// Wraps or saturates at the limits, sanitises the load value, decodes the
// terminal count combinationally, and gives a registered overflow/underflow
// pulse.
//
// Parameters:
//   DIGITS   number of BCD digits (1..8); count range 0 .. 10^DIGITS-1
// Ports:
//   CLK      rising-edge clock
//   RESET_B  asynchronous active-low reset (Q=0, OVF=0)
//   CLR      synchronous clear, highest synchronous priority
//   LOAD     synchronous load from IN; digits 10..15 are clamped to 9
//   EN       count enable
//   UP       direction: 1 = increment, 0 = decrement
//   SAT      limit mode: 1 = saturate, 0 = wrap
//   IN       load value, digit k in IN[4k+3:4k]
//   Q        registered count, same packing as IN
//   TC       terminal count: all 9s when UP=1, all 0s when UP=0
//   OVF      one-cycle pulse after an edge that counted at the terminal count
module bcd_updown_cnt_n #(
   parameter int unsigned DIGITS = 2
) (
   input  logic                  CLK,
   input  logic                  RESET_B,
   input  logic                  CLR,
   input  logic                  LOAD,
   input  logic                  EN,
   input  logic                  UP,
   input  logic                  SAT,
   input  logic [4*DIGITS-1:0]   IN,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  TC,
   output logic                  OVF
);

   logic [4*DIGITS-1:0] count_q, count_d;
   logic                ovf_q, ovf_d;
   logic [4*DIGITS-1:0] nines;
   logic                all_nine, all_zero;
   logic                chain;
   logic [3:0]          digit;

   // Terminal count depends only on the present count and direction.
   always_comb begin
      all_nine = 1'b1;
      all_zero = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         all_nine = all_nine & (count_q[4*k +: 4] == 4'd9);
         all_zero = all_zero & (count_q[4*k +: 4] == 4'd0);
      end
      TC = UP ? all_nine : all_zero;
   end

   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      chain   = 1'b1;
      digit   = 4'd0;
      nines   = '0;
      for (int k = 0; k < DIGITS; k++) begin
         nines[4*k +: 4] = 4'd9;
      end

      if (CLR) begin
         count_d = '0;
      end else if (LOAD) begin
         for (int k = 0; k < DIGITS; k++) begin
            count_d[4*k +: 4] = (IN[4*k +: 4] > 4'd9) ? 4'd9 : IN[4*k +: 4];
         end
      end else if (EN) begin
         if (TC) begin
            ovf_d = 1'b1;
            if (!SAT) begin
               count_d = UP ? '0 : nines;
            end
         end else begin
            // Ripple the carry/borrow: a digit steps only while every lower
            // digit sits at its rollover value.
            for (int k = 0; k < DIGITS; k++) begin
               digit = count_q[4*k +: 4];
               if (chain) begin
                  if (UP) begin
                     count_d[4*k +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
                  end else begin
                     count_d[4*k +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
                  end
               end
               chain = chain & (UP ? (digit == 4'd9) : (digit == 4'd0));
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign Q   = count_q;
   assign OVF = ovf_q;

endmodule

// File: tb/tb_bcd_updown_cnt_n.sv
module tb_bcd_updown_cnt_n;

   logic        CLK = 1'b0;
   logic        RESET_B;
   logic        clr, load, en, up, sat;
   logic [11:0] in_bus;
   logic [11:0] q3;
   logic [7:0]  q2;
   logic        tc3, tc2, ovf3, ovf2;

   int checks = 0;
   int errors = 0;
   bit started = 0;

   // Reference model: plain integer counts.
   int m3 = 0;
   int m2 = 0;
   bit mo3 = 0;
   bit mo2 = 0;

   always #5 CLK = ~CLK;

   bcd_updown_cnt_n #(.DIGITS(3)) u3 (
      .CLK(CLK), .RESET_B(RESET_B), .CLR(clr), .LOAD(load), .EN(en), .UP(up), .SAT(sat),
      .IN(in_bus), .Q(q3), .TC(tc3), .OVF(ovf3)
   );

   bcd_updown_cnt_n #(.DIGITS(2)) u2 (
      .CLK(CLK), .RESET_B(RESET_B), .CLR(clr), .LOAD(load), .EN(en), .UP(up), .SAT(sat),
      .IN(in_bus[7:0]), .Q(q2), .TC(tc2), .OVF(ovf2)
   );

   function automatic int pow10(int d);
      int r = 1;
      for (int i = 0; i < d; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [31:0] to_bcd(int v);
      logic [31:0] r = '0;
      int x = v;
      for (int k = 0; k < 8; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int clamp_load(logic [31:0] x, int d);
      int r = 0;
      int n;
      for (int k = d - 1; k >= 0; k--) begin
         n = int'(x[4*k +: 4]);
         if (n > 9) n = 9;
         r = r * 10 + n;
      end
      return r;
   endfunction

   function automatic int next_val(int v, int d);
      int mx = pow10(d) - 1;
      if (clr) return 0;
      if (load) return clamp_load({20'd0, in_bus}, d);
      if (!en) return v;
      if (up) return (v == mx) ? (sat ? mx : 0) : v + 1;
      return (v == 0) ? (sat ? 0 : mx) : v - 1;
   endfunction

   function automatic bit next_ovf(int v, int d);
      int lim = up ? pow10(d) - 1 : 0;
      return !clr && !load && en && (v == lim);
   endfunction

   function automatic bit model_tc(int v, int d);
      return up ? (v == pow10(d) - 1) : (v == 0);
   endfunction

   always @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         m3 = 0; m2 = 0; mo3 = 0; mo2 = 0;
      end else begin
         mo3 = next_ovf(m3, 3);
         mo2 = next_ovf(m2, 2);
         m3  = next_val(m3, 3);
         m2  = next_val(m2, 2);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge CLK) begin
      if (started) begin
         logic [31:0] e3, e2;
         e3 = to_bcd(m3);
         e2 = to_bcd(m2);
         chk("q3", {20'd0, q3}, {20'd0, e3[11:0]});
         chk("q2", {24'd0, q2}, {24'd0, e2[7:0]});
         chk("ovf3", {31'd0, ovf3}, {31'd0, mo3});
         chk("ovf2", {31'd0, ovf2}, {31'd0, mo2});
         chk("tc3", {31'd0, tc3}, {31'd0, model_tc(m3, 3)});
         chk("tc2", {31'd0, tc2}, {31'd0, model_tc(m2, 2)});
      end
   end

   task automatic drive(input logic c, input logic l, input logic e, input logic u,
                        input logic s, input logic [11:0] v);
      clr = c; load = l; en = e; up = u; sat = s; in_bus = v;
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RESET_B = 1'b0;
      drive(0, 0, 0, 1, 0, 12'h000);
      #12;
      RESET_B = 1'b1;
      started = 1;

      // Asynchronous reset mid-count
      drive(0, 1, 0, 1, 0, 12'h457); tick;
      chk("load_457", {20'd0, q3}, 32'h457);
      drive(0, 0, 1, 1, 0, 12'h000); tick;
      chk("count_458", {20'd0, q3}, 32'h458);
      #2 RESET_B = 1'b0;
      #1 chk("rst_q", {20'd0, q3}, 32'h000);
      chk("rst_ovf", {31'd0, ovf3}, 32'd0);
      up = 1'b0;
      #1 chk("rst_tc_down", {31'd0, tc3}, 32'd1);
      up = 1'b1;
      #1 chk("rst_tc_up", {31'd0, tc3}, 32'd0);
      #1 RESET_B = 1'b1;

      // Up-count carry chain
      drive(0, 1, 0, 1, 0, 12'h098); tick;
      drive(0, 0, 1, 1, 0, 12'h000); tick;
      chk("up_099", {20'd0, q3}, 32'h099);
      tick;
      chk("up_100", {20'd0, q3}, 32'h100);
      chk("up_100_ovf", {31'd0, ovf3}, 32'd0);
      tick;
      chk("up_101", {20'd0, q3}, 32'h101);
      chk("up_101_tc", {31'd0, tc3}, 32'd0);

      // Wrap versus saturate
      drive(0, 1, 0, 1, 0, 12'h999); tick;
      chk("at_999_tc", {31'd0, tc3}, 32'd1);
      drive(0, 0, 1, 1, 0, 12'h000); tick;
      chk("wrap_000", {20'd0, q3}, 32'h000);
      chk("wrap_ovf", {31'd0, ovf3}, 32'd1);
      drive(0, 0, 0, 1, 0, 12'h000); tick;
      chk("wrap_ovf_drop", {31'd0, ovf3}, 32'd0);
      drive(0, 1, 0, 1, 1, 12'h999); tick;
      drive(0, 0, 1, 1, 1, 12'h000);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("sat_hold", {20'd0, q3}, 32'h999);
         chk("sat_ovf", {31'd0, ovf3}, 32'd1);
      end

      // Down-count borrow and underflow
      drive(0, 1, 0, 0, 0, 12'h100); tick;
      drive(0, 0, 1, 0, 0, 12'h000); tick;
      chk("down_099", {20'd0, q3}, 32'h099);
      tick;
      chk("down_098", {20'd0, q3}, 32'h098);
      drive(0, 1, 0, 0, 0, 12'h000); tick;
      drive(0, 0, 1, 0, 0, 12'h000); tick;
      chk("under_999", {20'd0, q3}, 32'h999);
      chk("under_ovf", {31'd0, ovf3}, 32'd1);

      // Load clamping
      drive(0, 1, 0, 1, 0, 12'h0FA); tick;
      chk("clamp_fa", {24'd0, q2}, 32'h99);
      drive(0, 1, 0, 1, 0, 12'h03C); tick;
      chk("clamp_3c", {24'd0, q2}, 32'h39);

      // Priority
      drive(0, 1, 0, 1, 0, 12'h042); tick;
      drive(1, 1, 1, 1, 0, 12'h055); tick;
      chk("clr_wins", {24'd0, q2}, 32'h00);
      drive(0, 1, 1, 1, 0, 12'h017); tick;
      chk("load_wins", {24'd0, q2}, 32'h17);
      chk("load_wins_ovf", {31'd0, ovf2}, 32'd0);

      // Randomised run against the model
      for (int i = 0; i < 3000; i++) begin
         logic [11:0] v;
         case ($urandom_range(0, 4))
            0: v = 12'h999;
            1: v = 12'h000;
            2: v = 12'h998;
            default: v = 12'($urandom);
         endcase
         drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 1) == 1), v);
         tick;
         if ($urandom_range(0, 63) == 0) begin
            #2 RESET_B = 1'b0;
            #1 chk("rand_rst_q", {20'd0, q3}, 32'h000);
            @(negedge CLK);
            #1 RESET_B = 1'b1;
         end
      end

      @(negedge CLK);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
